// File: rtl/keccak_seq_pkg.sv
// Shared state encoding and step/round constants for the Keccak round sequencer.
// The default step order follows the theta..iota chain of one permutation round.
package keccak_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_LAUNCH    = 3'd2,
        S_ACK       = 3'd3,
        S_RUN       = 3'd4,
        S_ADVANCE   = 3'd5,
        S_ROUND_END = 3'd6,
        S_DONE      = 3'd7
    } seq_state_e;

    localparam int STEP_THETA = 0;
    localparam int STEP_RHO   = 1;
    localparam int STEP_PI    = 2;
    localparam int STEP_CHI   = 3;
    localparam int STEP_IOTA  = 4;

    localparam int DEFAULT_ROUNDS = 24;

endpackage

// File: rtl/seq_watchdog.sv
// Per-step watchdog: cleared at launch, counts while enabled, flags expiry
// on the TIMEOUT-th counted cycle. TIMEOUT of zero never expires.
module seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/keccak_round_sequencer.sv
// Round sequencer: walks enabled step units in index order once per round,
// with per-step watchdog, abort and round/step index outputs.
module keccak_round_sequencer
    import keccak_seq_pkg::*;
#(
    parameter int N_STEPS    = 5,
    parameter int MAX_ROUNDS = DEFAULT_ROUNDS,
    parameter int RND_W      = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [RND_W-1:0]           i_num_rounds,
    input  logic [N_STEPS-1:0]         i_step_mask,
    input  logic                       i_abort,
    input  logic [N_STEPS-1:0]         i_step_ready,
    output logic                       o_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [N_STEPS-1:0]         o_step_start,
    output logic                       o_cnt_up,
    output logic [RND_W-1:0]           o_round_idx,
    output logic [$clog2(N_STEPS)-1:0] o_step_idx,
    output logic                       o_last_round
);

    localparam int SW = $clog2(N_STEPS);

    seq_state_e         r_state;
    seq_state_e         w_next;
    logic [SW-1:0]      r_step;
    logic [RND_W-1:0]   r_round;
    logic [RND_W-1:0]   r_rounds_q;
    logic [N_STEPS-1:0] r_mask_q;
    logic               r_err;

    logic               w_accept;
    logic               w_expire;
    logic               w_wd_en;
    logic               w_wd_clr;
    logic               w_cur_ready;
    logic               w_last_step;
    logic               w_last_round;
    logic [RND_W-1:0]   w_rounds_clamped;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_wd_en      = (r_state == S_ACK) || (r_state == S_RUN);
    assign w_wd_clr     = (r_state == S_LAUNCH);
    assign w_cur_ready  = i_step_ready[r_step];
    assign w_last_step  = (r_step == SW'(N_STEPS - 1));
    assign w_last_round = (r_round == r_rounds_q - RND_W'(1));

    assign w_rounds_clamped = (i_num_rounds > RND_W'(MAX_ROUNDS)) ?
                              RND_W'(MAX_ROUNDS) : i_num_rounds;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort outranks every transition, the watchdog outranks unit progress.
    always_comb begin
        w_next = r_state;
        if (r_state != S_IDLE && i_abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_next = (i_num_rounds == '0) ? S_DONE : S_SELECT;
                    end
                end
                S_SELECT:    w_next = r_mask_q[r_step] ? S_LAUNCH : S_ADVANCE;
                S_LAUNCH:    w_next = S_ACK;
                S_ACK: begin
                    if (w_expire) begin
                        w_next = S_IDLE;
                    end else if (!w_cur_ready) begin
                        w_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_expire) begin
                        w_next = S_IDLE;
                    end else if (w_cur_ready) begin
                        w_next = S_ADVANCE;
                    end
                end
                S_ADVANCE:   w_next = w_last_step ? S_ROUND_END : S_SELECT;
                S_ROUND_END: w_next = w_last_round ? S_DONE : S_SELECT;
                S_DONE:      w_next = S_IDLE;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready      = (r_state == S_IDLE);
        o_busy       = (r_state != S_IDLE);
        o_done       = (r_state == S_DONE);
        o_cnt_up     = (r_state == S_ROUND_END);
        o_step_start = '0;
        if (r_state == S_LAUNCH) begin
            o_step_start[r_step] = 1'b1;
        end
        o_error      = r_err;
        o_round_idx  = r_round;
        o_step_idx   = r_step;
        o_last_round = (r_state != S_IDLE) && w_last_round;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rounds_q <= '0;
            r_mask_q   <= '0;
            r_round    <= '0;
            r_step     <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_rounds_q <= w_rounds_clamped;
            r_mask_q   <= i_step_mask;
            r_round    <= '0;
            r_step     <= '0;
            r_err      <= 1'b0;
        end else if (!i_abort) begin
            if (w_expire) begin
                r_err <= 1'b1;
            end
            if (r_state == S_ADVANCE) begin
                r_step <= w_last_step ? '0 : r_step + SW'(1);
            end
            if (r_state == S_ROUND_END && !w_last_round) begin
                r_round <= r_round + RND_W'(1);
            end
        end
    end

endmodule
